// File: rtl/spike_window_counter.sv
// Spike window counter: counts spikes per channel over a programmable
// window of enabled cycles, records each channel's first-spike latency and
// presents the result as one latched record on a valid/ready handshake.
module spike_window_counter #(
  parameter int N_CHANNELS  = 2,
  parameter int COUNT_BITS  = 8,
  parameter int WINDOW_BITS = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [N_CHANNELS-1:0]             spike,
  input  logic [WINDOW_BITS-1:0]            window_len,
  input  logic                              start,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_CHANNELS*COUNT_BITS-1:0]  out_count,
  output logic [N_CHANNELS*WINDOW_BITS-1:0] out_latency,
  output logic [N_CHANNELS-1:0]             out_fired,
  output logic [N_CHANNELS-1:0]             out_saturated
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_BITS-1:0]  CNT_MAX  = {COUNT_BITS{1'b1}};
  localparam logic [COUNT_BITS-1:0]  CNT_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_BITS-1:0] LAT_NONE = {WINDOW_BITS{1'b1}};
  localparam logic [WINDOW_BITS-1:0] IDX_ONE  = {{(WINDOW_BITS-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_BITS-1:0] WL_ZERO  = {WINDOW_BITS{1'b0}};
  // remaining is one bit wider so that window_len=0 can stand for 2^WINDOW_BITS
  localparam logic [WINDOW_BITS:0]   REM_ONE  = {{WINDOW_BITS{1'b0}}, 1'b1};
  localparam logic [WINDOW_BITS:0]   REM_FULL = {1'b1, {WINDOW_BITS{1'b0}}};

  state_t                                   state_r, state_next_s;
  logic [WINDOW_BITS:0]                     remaining_r, remaining_next_s;
  logic [WINDOW_BITS-1:0]                   index_r, index_next_s;
  logic [N_CHANNELS-1:0][COUNT_BITS-1:0]    count_r, count_next_s;
  logic [N_CHANNELS-1:0][WINDOW_BITS-1:0]   lat_r, lat_next_s, lat_rec_s;
  logic [N_CHANNELS-1:0]                    fired_r, fired_next_s;
  logic [N_CHANNELS-1:0]                    sat_r, sat_next_s;
  logic                                     open_s, sample_s, last_s, rec_load_s;

  // Next-state logic: window open, per-sample accumulation and handshake
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    index_next_s     = index_r;
    count_next_s     = count_r;
    lat_next_s       = lat_r;
    fired_next_s     = fired_r;
    sat_next_s       = sat_r;
    open_s           = 1'b0;
    sample_s         = 1'b0;
    last_s           = 1'b0;
    rec_load_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) open_s = 1'b1;
        else       state_next_s = IDLE;
      end
      COUNT: begin
        if (enable) begin
          sample_s = 1'b1;
          if (remaining_r == REM_ONE) last_s = 1'b1;
          else                        last_s = 1'b0;
        end else begin
          sample_s = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) open_s = 1'b1;
          else       state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase

    if (open_s) begin
      state_next_s = COUNT;
      if (window_len == WL_ZERO) remaining_next_s = REM_FULL;
      else                       remaining_next_s = {1'b0, window_len};
      index_next_s = WL_ZERO;
      count_next_s = '{default: {COUNT_BITS{1'b0}}};
      lat_next_s   = '{default: {WINDOW_BITS{1'b0}}};
      fired_next_s = {N_CHANNELS{1'b0}};
      sat_next_s   = {N_CHANNELS{1'b0}};
    end else if (sample_s) begin
      remaining_next_s = remaining_r - REM_ONE;
      index_next_s     = index_r + IDX_ONE;
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (spike[i]) begin
          if (count_r[i] != CNT_MAX) count_next_s[i] = count_r[i] + CNT_ONE;
          else                       count_next_s[i] = count_r[i];
          if (count_next_s[i] == CNT_MAX) sat_next_s[i] = 1'b1;
          else                            sat_next_s[i] = sat_r[i];
          // only the first spike of the window sets the latency
          if (!fired_r[i]) begin
            lat_next_s[i]   = index_r;
            fired_next_s[i] = 1'b1;
          end else begin
            lat_next_s[i]   = lat_r[i];
            fired_next_s[i] = fired_r[i];
          end
        end else begin
          count_next_s[i] = count_r[i];
        end
      end
      if (last_s) state_next_s = HOLD;
      else        state_next_s = COUNT;
      rec_load_s = last_s;
    end else begin
      rec_load_s = 1'b0;
    end
  end

  // Record latency view: unfired channels report the all-ones marker
  always_comb begin
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (fired_next_s[i]) lat_rec_s[i] = lat_next_s[i];
      else                 lat_rec_s[i] = LAT_NONE;
    end
  end

  // State, working counters and registered output record
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      remaining_r   <= {(WINDOW_BITS+1){1'b0}};
      index_r       <= WL_ZERO;
      count_r       <= '{default: {COUNT_BITS{1'b0}}};
      lat_r         <= '{default: {WINDOW_BITS{1'b0}}};
      fired_r       <= {N_CHANNELS{1'b0}};
      sat_r         <= {N_CHANNELS{1'b0}};
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      out_count     <= {(N_CHANNELS*COUNT_BITS){1'b0}};
      out_latency   <= {(N_CHANNELS*WINDOW_BITS){1'b0}};
      out_fired     <= {N_CHANNELS{1'b0}};
      out_saturated <= {N_CHANNELS{1'b0}};
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      index_r     <= index_next_s;
      count_r     <= count_next_s;
      lat_r       <= lat_next_s;
      fired_r     <= fired_next_s;
      sat_r       <= sat_next_s;
      busy        <= (state_next_s == COUNT);
      out_valid   <= (state_next_s == HOLD);
      if (rec_load_s) begin
        out_count     <= count_next_s;
        out_latency   <= lat_rec_s;
        out_fired     <= fired_next_s;
        out_saturated <= sat_next_s;
      end else begin
        out_count     <= out_count;
        out_latency   <= out_latency;
        out_fired     <= out_fired;
        out_saturated <= out_saturated;
      end
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
// Self-checking bench for spike_window_counter: directed scenarios plus
// randomized windows, checked against a sample-list reference model.
module tb_spike_window_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  spike;
  logic [7:0]  window_len;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_count;
  logic [15:0] out_latency;
  logic [1:0]  out_fired;
  logic [1:0]  out_saturated;

  int n_checks = 0;
  int n_errors = 0;

  // spike vectors of the enabled samples of the current window, in order
  logic [1:0]  samples[$];
  // expected record currently presented on the out_* ports
  logic [15:0] rec_cnt;
  logic [15:0] rec_lat;
  logic [1:0]  rec_fired;
  logic [1:0]  rec_sat;

  spike_window_counter #(
    .N_CHANNELS(2), .COUNT_BITS(8), .WINDOW_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .spike(spike),
    .window_len(window_len), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_latency(out_latency), .out_fired(out_fired),
    .out_saturated(out_saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_record(input string tag);
    chk({tag, "_count"}, 64'(out_count), 64'(rec_cnt));
    chk({tag, "_latency"}, 64'(out_latency), 64'(rec_lat));
    chk({tag, "_fired"}, 64'(out_fired), 64'(rec_fired));
    chk({tag, "_saturated"}, 64'(out_saturated), 64'(rec_sat));
  endtask

  // Reference: rate code computed directly from the list of samples
  task automatic compute_model();
    for (int c = 0; c < 2; c++) begin
      int sum = 0;
      int first = -1;
      for (int i = 0; i < samples.size(); i++) begin
        if (samples[i][c]) begin
          sum++;
          if (first < 0) first = i;
        end
      end
      rec_cnt[c*8 +: 8] = (sum > 255) ? 8'd255 : 8'(sum);
      rec_sat[c]        = (sum >= 255);
      rec_fired[c]      = (first >= 0);
      rec_lat[c*8 +: 8] = (first >= 0) ? 8'(first) : 8'hFF;
    end
  endtask

  // en_mode: 0 random, 1 always, 2 pattern 1,0,0,1,1,0,1 then 1
  // sp_mode: 0 random, 1 ch0 on samples 2/5/9, 2 both always, 3 ch1 always
  task automatic run_window(input int w, input bit started, input int en_mode,
                            input int sp_mode, input int hold, input bit restart,
                            input int next_w, input int start_at);
    int nsamp = 0;
    int k = 0;
    logic [7:0] wl;
    logic en;
    logic [1:0] sp;
    samples.delete();
    if (!started) begin
      wl = w[7:0];
      window_len = wl;
      start = 1'b1;
      enable = 1'($urandom_range(0, 1));
      spike = 2'($urandom_range(0, 3));
      tick();
      start = 1'b0;
    end
    chk("open_busy", 64'(busy), 64'd1);
    chk("open_valid", 64'(out_valid), 64'd0);
    check_record("open_prev");
    while (nsamp < w) begin
      case (en_mode)
        1:       en = 1'b1;
        2:       en = (k < 7) ? ((k == 0) || (k == 3) || (k == 4) || (k == 6)) : 1'b1;
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      case (sp_mode)
        1:       sp = {1'b0, (nsamp == 2) || (nsamp == 5) || (nsamp == 9)};
        2:       sp = 2'b11;
        3:       sp = 2'b10;
        default: sp = 2'($urandom_range(0, 3));
      endcase
      enable = en;
      spike = sp;
      start = (nsamp == start_at) ? 1'b1 : 1'b0;
      window_len = 8'($urandom_range(0, 255));
      tick();
      start = 1'b0;
      k++;
      if (en) begin
        samples.push_back(sp);
        nsamp++;
      end
      if (nsamp < w) begin
        if (busy !== 1'b1 || out_valid !== 1'b0)
          chk("count_phase_busy_valid", {62'd0, busy, out_valid}, 64'd2);
        if (out_count !== rec_cnt) chk("count_phase_record", 64'(out_count), 64'(rec_cnt));
      end
      if (k > 2000) begin
        chk("window_timeout", 64'(nsamp), 64'(w));
        break;
      end
    end
    compute_model();
    chk("done_valid", 64'(out_valid), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    check_record("done");
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      enable = 1'($urandom_range(0, 1));
      spike = 2'($urandom_range(0, 3));
      start = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      check_record("hold");
    end
    out_ready = 1'b1;
    start = restart;
    wl = next_w[7:0];
    window_len = wl;
    enable = 1'($urandom_range(0, 1));
    spike = 2'($urandom_range(0, 3));
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("accept_valid", 64'(out_valid), 64'd0);
    chk("accept_busy", 64'(busy), 64'(restart));
    check_record("accept_retain");
    if (!restart) begin
      repeat (2) begin
        start = 1'b0;
        enable = 1'b1;
        spike = 2'b11;
        tick();
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    bit pending;
    int nw;
    reset = 1'b1; enable = 1'b0; spike = 2'b00; window_len = 8'd0;
    start = 1'b0; out_ready = 1'b0;
    rec_cnt = 16'd0; rec_lat = 16'd0; rec_fired = 2'b00; rec_sat = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    check_record("reset");

    // basic count, stalls, saturation over 256 samples
    run_window(10, 1'b0, 1, 1, 0, 1'b0, 0, -1);
    run_window(4, 1'b0, 2, 3, 0, 1'b0, 0, -1);
    run_window(256, 1'b0, 1, 2, 0, 1'b0, 0, -1);
    // backpressure followed by back-to-back restart
    run_window(12, 1'b0, 0, 0, 20, 1'b1, 7, -1);
    run_window(7, 1'b1, 0, 0, 0, 1'b0, 0, -1);

    // reset mid-window aborts without producing a record
    window_len = 8'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    repeat (20) begin
      spike = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rec_cnt = 16'd0; rec_lat = 16'd0; rec_fired = 2'b00; rec_sat = 2'b00;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_valid", 64'(out_valid), 64'd0);
    check_record("midreset");
    run_window(30, 1'b0, 0, 0, 1, 1'b0, 0, -1);

    // start during COUNT is ignored
    run_window(8, 1'b0, 1, 0, 0, 1'b0, 0, 3);
    run_window(1, 1'b0, 0, 0, 2, 1'b0, 0, -1);

    // randomized windows, with occasional back-to-back restarts
    pending = 1'b0;
    nw = $urandom_range(1, 40);
    for (int r = 0; r < 10; r++) begin
      int cur;
      bit rs;
      cur = nw;
      nw = $urandom_range(1, 40);
      rs = 1'($urandom_range(0, 1));
      run_window(cur, pending, 0, 0, $urandom_range(0, 3), rs, nw, -1);
      pending = rs;
    end
    if (pending) run_window(nw, 1'b1, 1, 0, 0, 1'b0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
